dcache_control_nway: RTL and testbench

Parametrised N-way set-associative, write-back/write-allocate L1 data-cache controller; the next generation of the team's 2-way dcache controller. Sits between the pipeline MEM stage (dcache_read/dcache_write/dcache_resp) and the L2 interface, driving per-way valid/dirty/tag/data write enables, tree pseudo-LRU state and the write-back address mux. Adds a registered victim way, invalid-first replacement, synchronous reset and saturating performance counters.

---
 rtl/dcache_control_nway.sv | 233 +++++++++++++++++++++++
 tb/tb_dcache_control_nway.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_control_nway.sv
// N-way set-associative write-back/write-allocate L1 data-cache controller.
// Handles hit/miss, tree-PLRU replacement with invalid-first victim choice, the L2 handshake and saturating counters.
module dcache_control_nway #(
  parameter int WAYS      = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dcache_read,
  input  logic                 dcache_write,
  output logic                 dcache_resp,
  input  logic [WAYS-1:0]      hit,
  input  logic [WAYS-1:0]      valid_dataout,
  input  logic [WAYS-1:0]      dirty_dataout,
  input  logic [WAYS-2:0]      plru_dataout,
  output logic [WAYS-1:0]      valid_write,
  output logic [WAYS-1:0]      valid_datain,
  output logic [WAYS-1:0]      dirty_write,
  output logic [WAYS-1:0]      dirty_datain,
  output logic [WAYS-1:0]      tag_write,
  output logic [WAYS-1:0]      data_write,
  output logic                 plru_write,
  output logic [WAYS-2:0]      plru_datain,
  output logic                 replacemux_sel,
  output logic                 L2_read,
  output logic                 L2_write,
  input  logic                 L2_resp,
  output logic                 pmemaddressmux_sel,
  input  logic                 counter_clear,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  localparam int WB = $clog2(WAYS);

  typedef enum logic [2:0] {
    COMPARE    = 3'd0,
    WRITE_BACK = 3'd1,
    CLEAN      = 3'd2,
    FILL       = 3'd3,
    INSTALL    = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [WB-1:0]        victim;
  logic [WB-1:0]        victim_sel;
  logic                 victim_dirty;
  logic                 miss_flag;
  logic                 request;
  logic [WAYS-1:0]      eff_hit;
  logic                 any_hit;
  logic [WB-1:0]        hit_way;
  logic [WAYS-1:0]      hit_onehot;
  logic [WAYS-1:0]      victim_onehot;
  logic                 miss_event;
  logic                 wb_event;
  logic                 hit_event;
  logic [WAYS-1:0]      one_way;
  logic [CNT_WIDTH-1:0] cnt_one;

  function automatic logic [WB-1:0] lowest_index(input logic [WAYS-1:0] vec);
    logic [WB-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      idx = vec[i] ? WB'(i) : idx;
    end
    return idx;
  endfunction

  // Walk the tree from the root: a 0 bit descends to the lower half, a 1 bit to the upper half.
  function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [WB-1:0] way;
    logic [WB-1:0] node;
    logic          dir;
    way  = '0;
    node = '0;
    for (int lvl = 0; lvl < WB; lvl++) begin
      dir  = tree[node];
      way  = (way << 1) | WB'(dir);
      node = (node << 1) + (dir ? WB'(2'd2) : WB'(2'd1));
    end
    return way;
  endfunction

  // Point every node on the touched way's path towards the other half.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree, input logic [WB-1:0] way);
    logic [WAYS-2:0] upd;
    logic [WB-1:0]   node;
    logic [WB-1:0]   path;
    logic            dir;
    upd  = tree;
    node = '0;
    path = way;
    for (int lvl = 0; lvl < WB; lvl++) begin
      dir       = path[WB-1];
      upd[node] = ~dir;
      path      = path << 1;
      node      = (node << 1) + (dir ? WB'(2'd2) : WB'(2'd1));
    end
    return upd;
  endfunction

  assign one_way       = {{(WAYS-1){1'b0}}, 1'b1};
  assign cnt_one       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  assign request       = dcache_read | dcache_write;
  assign eff_hit       = hit & valid_dataout;
  assign any_hit       = |eff_hit;
  assign hit_way       = lowest_index(eff_hit);
  assign hit_onehot    = one_way << hit_way;
  assign victim_sel    = (&valid_dataout) ? plru_victim(plru_dataout) : lowest_index(~valid_dataout);
  assign victim_dirty  = valid_dataout[victim_sel] & dirty_dataout[victim_sel];
  assign victim_onehot = one_way << victim;
  assign miss_event    = (state == COMPARE) && request && !any_hit;
  assign wb_event      = (state == WRITE_BACK) && L2_resp;
  assign hit_event     = dcache_resp && !miss_flag;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COMPARE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; L2_resp only matters while waiting on L2.
  always_comb begin
    next_state = state;
    case (state)
      COMPARE:    next_state = miss_event ? (victim_dirty ? WRITE_BACK : FILL) : COMPARE;
      WRITE_BACK: next_state = L2_resp ? CLEAN : WRITE_BACK;
      CLEAN:      next_state = FILL;
      FILL:       next_state = L2_resp ? INSTALL : FILL;
      INSTALL:    next_state = COMPARE;
      default:    next_state = COMPARE;
    endcase
  end

  // Output decode per state.
  always_comb begin
    dcache_resp        = 1'b0;
    valid_write        = '0;
    valid_datain       = '0;
    dirty_write        = '0;
    dirty_datain       = '0;
    tag_write          = '0;
    data_write         = '0;
    plru_write         = 1'b0;
    plru_datain        = '0;
    replacemux_sel     = 1'b0;
    L2_read            = 1'b0;
    L2_write           = 1'b0;
    pmemaddressmux_sel = 1'b0;
    case (state)
      COMPARE: begin
        if (request && any_hit) begin
          dcache_resp    = 1'b1;
          plru_write     = 1'b1;
          plru_datain    = plru_touch(plru_dataout, hit_way);
          replacemux_sel = dcache_write;
          data_write     = dcache_write ? hit_onehot : '0;
          dirty_write    = dcache_write ? hit_onehot : '0;
          dirty_datain   = dcache_write ? hit_onehot : '0;
        end else begin
          dcache_resp = 1'b0;
        end
      end
      WRITE_BACK: begin
        L2_write           = 1'b1;
        pmemaddressmux_sel = 1'b1;
      end
      CLEAN: begin
        pmemaddressmux_sel = 1'b1;
        dirty_write        = victim_onehot;
      end
      FILL: begin
        L2_read    = 1'b1;
        data_write = victim_onehot;
        tag_write  = victim_onehot;
      end
      INSTALL: begin
        valid_write  = victim_onehot;
        valid_datain = victim_onehot;
        dirty_write  = dcache_write ? victim_onehot : '0;
        dirty_datain = dcache_write ? victim_onehot : '0;
      end
      default: begin
        dcache_resp = 1'b0;
      end
    endcase
  end

  // Victim is captured once at miss detection so later set-state changes cannot move it.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim <= '0;
    end else if (miss_event) begin
      victim <= victim_sel;
    end else begin
      victim <= victim;
    end
  end

  // Marks that the current request missed, so its final response is not counted as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_flag <= 1'b0;
    end else if (dcache_resp) begin
      miss_flag <= 1'b0;
    end else if (miss_event) begin
      miss_flag <= 1'b1;
    end else begin
      miss_flag <= miss_flag;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || counter_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      hit_count  <= (hit_event && hit_count != '1) ? hit_count + cnt_one : hit_count;
      miss_count <= (miss_event && miss_count != '1) ? miss_count + cnt_one : miss_count;
      wb_count   <= (wb_event && wb_count != '1) ? wb_count + cnt_one : wb_count;
    end
  end

endmodule

// File: tb/tb_dcache_control_nway.sv
// Scoreboard bench for dcache_control_nway: stimulus pushes expectations from a tree-walk reference model,
// a negedge monitor pops and compares whenever the controller responds, writes back, cleans, fills or installs.
module tb_dcache_control_nway;
  localparam int WAYS = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            dcache_read, dcache_write, dcache_resp;
  logic [WAYS-1:0] hit, valid_dataout, dirty_dataout;
  logic [WAYS-2:0] plru_dataout;
  logic [WAYS-1:0] valid_write, valid_datain, dirty_write, dirty_datain, tag_write, data_write;
  logic            plru_write;
  logic [WAYS-2:0] plru_datain;
  logic            replacemux_sel, L2_read, L2_write, L2_resp, pmemaddressmux_sel, counter_clear;
  logic [CW-1:0]   hit_count, miss_count, wb_count;

  dcache_control_nway #(.WAYS(WAYS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_resp(dcache_resp),
    .hit(hit), .valid_dataout(valid_dataout), .dirty_dataout(dirty_dataout), .plru_dataout(plru_dataout),
    .valid_write(valid_write), .valid_datain(valid_datain), .dirty_write(dirty_write), .dirty_datain(dirty_datain),
    .tag_write(tag_write), .data_write(data_write), .plru_write(plru_write), .plru_datain(plru_datain),
    .replacemux_sel(replacemux_sel), .L2_read(L2_read), .L2_write(L2_write), .L2_resp(L2_resp),
    .pmemaddressmux_sel(pmemaddressmux_sel), .counter_clear(counter_clear),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int start; int lat; logic wr; int way; logic [WAYS-2:0] plru; } resp_t;
  typedef struct { int way; logic wb; logic wr; } miss_t;
  typedef struct { int at; int h; int m; int w; logic idle; } cnt_t;

  resp_t rq[$];
  miss_t mq[$];
  cnt_t  cq[$];
  int    checks = 0;
  int    errors = 0;
  logic  end_chk = 1'b0;
  int    mh = 0, mm = 0, mw = 0;
  logic [WAYS-1:0] rv, rh, rd;
  logic [WAYS-2:0] rp;

  function automatic logic [WAYS-1:0] oh(input int w);
    logic [WAYS-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return one << w;
  endfunction

  function automatic logic bit_of(input logic [WAYS-1:0] vec, input int i);
    logic [WAYS-1:0] s;
    s = vec >> i;
    return s[0];
  endfunction

  function automatic int m_lowest(input logic [WAYS-1:0] vec);
    for (int i = 0; i < WAYS; i++) if (bit_of(vec, i)) return i;
    return -1;
  endfunction

  // Reference victim: first invalid way, otherwise follow the tree by halving the way range.
  function automatic int m_victim(input logic [WAYS-1:0] valid, input logic [WAYS-2:0] p);
    int lo, hi, mid, node;
    logic [WAYS-2:0] s;
    if (m_lowest(~valid) >= 0) return m_lowest(~valid);
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      s = p >> node;
      if (s[0]) begin lo = mid; node = 2 * node + 2; end
      else begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  function automatic logic [WAYS-2:0] m_plru(input logic [WAYS-2:0] p, input int h);
    int lo, hi, mid, node;
    logic [WAYS-2:0] one;
    one = '0; one[0] = 1'b1;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (h < mid) begin p = p | (one << node); hi = mid; node = 2 * node + 1; end
      else begin p = p & ~(one << node); lo = mid; node = 2 * node + 2; end
    end
    return p;
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every observable controller action against the queued expectations.
  always @(negedge clk) begin : mon
    resp_t r;
    miss_t m;
    cnt_t  k;
    if (!rst) begin
      if (rq.size() > 0 && cyc - rq[0].start > 60) begin
        r = rq.pop_front();
        chk("resp_timeout", cyc - r.start, r.lat);
      end
      if (dcache_resp) begin
        if (rq.size() == 0) chk("resp_spurious", dcache_resp, 0);
        else begin
          r = rq.pop_front();
          chk("resp_latency", cyc - r.start, r.lat);
          chk("hit_plru_write", plru_write, 1);
          chk("hit_plru_datain", plru_datain, r.plru);
          chk("hit_replacemux", replacemux_sel, r.wr);
          chk("hit_data_write", data_write, r.wr ? oh(r.way) : '0);
          chk("hit_dirty_write", dirty_write, r.wr ? oh(r.way) : '0);
          chk("hit_dirty_datain", dirty_datain, r.wr ? oh(r.way) : '0);
          chk("hit_quiet", {tag_write, valid_write, L2_read, L2_write, pmemaddressmux_sel}, '0);
        end
      end
      if (valid_write != '0) begin
        if (mq.size() == 0) chk("install_spurious", valid_write, 0);
        else begin
          m = mq.pop_front();
          chk("install_valid_write", valid_write, oh(m.way));
          chk("install_valid_datain", valid_datain, oh(m.way));
          chk("install_dirty_write", dirty_write, m.wr ? oh(m.way) : '0);
          chk("install_dirty_datain", dirty_datain, m.wr ? oh(m.way) : '0);
          chk("install_quiet", {tag_write, data_write, L2_read, L2_write, plru_write, dcache_resp}, '0);
        end
      end
      if (dirty_write != '0 && valid_write == '0 && !dcache_resp) begin
        if (mq.size() == 0) chk("clean_spurious", dirty_write, 0);
        else begin
          chk("clean_needs_wb", 32'(mq[0].wb), 1);
          chk("clean_dirty_write", dirty_write, oh(mq[0].way));
          chk("clean_dirty_datain", dirty_datain, 0);
          chk("clean_addr_sel", pmemaddressmux_sel, 1);
          chk("clean_l2_idle", {L2_read, L2_write}, 0);
        end
      end
      if (L2_write) begin
        if (mq.size() == 0) chk("wb_spurious", L2_write, 0);
        else begin
          chk("wb_needed", 32'(mq[0].wb), 1);
          chk("wb_addr_sel", pmemaddressmux_sel, 1);
          chk("wb_quiet", {L2_read, data_write, tag_write}, 0);
        end
      end
      if (L2_read) begin
        if (mq.size() == 0) chk("fill_spurious", L2_read, 0);
        else begin
          chk("fill_tag_write", tag_write, oh(mq[0].way));
          chk("fill_data_write", data_write, oh(mq[0].way));
          chk("fill_quiet", {pmemaddressmux_sel, L2_write, replacemux_sel}, 0);
        end
      end
      while (cq.size() > 0 && cq[0].at <= cyc) begin
        k = cq.pop_front();
        chk("hit_count", hit_count, k.h);
        chk("miss_count", miss_count, k.m);
        chk("wb_count", wb_count, k.w);
        if (k.idle)
          chk("idle_outputs", {dcache_resp, L2_read, L2_write, plru_write, tag_write, data_write,
                               valid_write, dirty_write, pmemaddressmux_sel, replacemux_sel}, '0);
      end
      if (end_chk) begin
        chk("rq_drained", rq.size(), 0);
        chk("mq_drained", mq.size(), 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; dcache_read = 1'b0; dcache_write = 1'b0; counter_clear = 1'b1; L2_resp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; counter_clear = 1'b0;
    rq.delete(); mq.delete(); cq.delete();
    mh = 0; mm = 0; mw = 0;
    cq.push_back('{at: cyc, h: 0, m: 0, w: 0, idle: 1'b1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      L2_resp = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    L2_resp = 1'b0;
  endtask

  // One request: model the outcome, queue expectations, then play the L2 side until it completes.
  task automatic do_req(input logic wr, input logic [WAYS-1:0] hv, input logic [WAYS-1:0] vv,
                        input logic [WAYS-1:0] dv, input logic [WAYS-2:0] pv,
                        input int fn, input int wm, input logic clr);
    int h, v, cnt;
    logic wb, done;
    logic [WAYS-2:0] p2;
    resp_t r;
    miss_t m;
    h = m_lowest(hv & vv);
    v = 0; wb = 1'b0;
    p2 = (WAYS-1)'($urandom);
    hit = hv; valid_dataout = vv; dirty_dataout = dv; plru_dataout = pv;
    dcache_read = !wr; dcache_write = wr; counter_clear = clr && (h >= 0);
    r.start = cyc; r.wr = wr;
    if (h >= 0) begin
      r.lat = 0; r.way = h; r.plru = m_plru(pv, h);
      if (clr) begin mh = 0; mm = 0; mw = 0; end
      else mh = sat(mh);
    end else begin
      v = m_victim(vv, pv);
      wb = bit_of(vv, v) && bit_of(dv, v);
      r.lat = fn + 2 + (wb ? wm + 1 : 0); r.way = v; r.plru = m_plru(p2, v);
      m.way = v; m.wb = wb; m.wr = wr;
      mq.push_back(m);
      mm = sat(mm);
      if (wb) mw = sat(mw);
    end
    rq.push_back(r);
    cnt = 0; done = 1'b0;
    for (int c = 0; c < 70 && !done; c++) begin
      @(negedge clk);
      done = dcache_resp;
      if (L2_read || L2_write) begin
        cnt++;
        L2_resp = (cnt == (L2_write ? wm : fn));
      end else begin
        cnt = 0;
        L2_resp = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      counter_clear = 1'b0;
      if (c == 0 && h < 0) begin
        hit = oh(v); valid_dataout = vv | oh(v); dirty_dataout = WAYS'($urandom); plru_dataout = p2;
      end
      if (done) begin dcache_read = 1'b0; dcache_write = 1'b0; L2_resp = 1'b0; end
    end
    if (!done) do_reset();
    else cq.push_back('{at: cyc, h: mh, m: mm, w: mw, idle: 1'b0});
  endtask

  initial begin
    rst = 1'b1; dcache_read = 1'b0; dcache_write = 1'b0; L2_resp = 1'b0; counter_clear = 1'b0;
    hit = '0; valid_dataout = '0; dirty_dataout = '0; plru_dataout = '0;
    repeat (2) @(posedge clk); #1;
    do_reset();
    idle(1);
    do_req(1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 1, 1, 1'b0);
    idle(1);
    do_req(1'b1, 4'b0000, 4'b0111, 4'b0000, 3'b000, 3, 1, 1'b0);
    idle(1);
    do_req(1'b0, 4'b0000, 4'b1111, 4'b1111, 3'b000, 1, 2, 1'b0);
    idle(1);
    // Clean read miss left hanging in FILL, then reset mid-transaction.
    hit = '0; valid_dataout = 4'b0111; dirty_dataout = '0; plru_dataout = '0; dcache_read = 1'b1;
    mq.push_back('{way: 3, wb: 1'b0, wr: 1'b0});
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    do_reset();
    idle(1);
    for (int i = 0; i < 18; i++) begin
      rp = (WAYS-1)'($urandom);
      do_req(1'($urandom_range(0, 1)), oh($urandom_range(0, WAYS - 1)), 4'b1111, 4'b0000, rp, 1, 1, 1'b0);
    end
    do_req(1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1, 1, 1'b1);
    for (int i = 0; i < 150; i++) begin
      rv = WAYS'($urandom);
      if ($urandom_range(0, 2) == 0) rv = 4'b1111;
      rh = ($urandom_range(0, 1) == 1) ? WAYS'($urandom) : 4'b0000;
      rd = WAYS'($urandom);
      rp = (WAYS-1)'($urandom);
      do_req(1'($urandom_range(0, 1)), rh, rv, rd, rp, $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(0, 7) == 0);
      idle($urandom_range(0, 2));
    end
    end_chk = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
